// File: rtl/mult_accum_pipe.sv
// mult_accum_pipe: two-stage multiply-accumulate that sums BLOCK_LEN products per
// result, with valid/ready handshakes on both sides and a sticky overflow flag.
module mult_accum_pipe #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int SIGNED    = 0,
  parameter int BLOCK_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf
);

  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int CNT_WIDTH = $clog2(BLOCK_LEN) + 1;
  localparam int MSB       = ACC_WIDTH - 1;
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);

  logic                 stall;
  logic                 accept;
  logic                 advance;
  logic                 last;
  logic [P_WIDTH-1:0]   a_ext;
  logic [P_WIDTH-1:0]   b_ext;
  logic [P_WIDTH-1:0]   prod;
  logic [P_WIDTH-1:0]   p_reg;
  logic                 p_valid;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;
  logic                 ovf;
  logic                 ovf_acc;
  logic [CNT_WIDTH-1:0] cnt;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready & ~clr;
  assign advance  = p_valid & ~stall;
  assign last     = (cnt == LAST_CNT);

  // Widening both operands to the product width first keeps the truncated product exact in either mode.
  assign a_ext = {{B_WIDTH{IS_SIGNED & a[A_WIDTH-1]}}, a};
  assign b_ext = {{A_WIDTH{IS_SIGNED & b[B_WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;

  generate
    if (ACC_WIDTH > P_WIDTH) begin : g_ext
      assign p_ext = {{(ACC_WIDTH - P_WIDTH){IS_SIGNED & p_reg[P_WIDTH-1]}}, p_reg};
    end else begin : g_noext
      assign p_ext = p_reg;
    end
  endgenerate

  assign {carry, sum} = {1'b0, acc} + {1'b0, p_ext};
  assign ovf = IS_SIGNED ? ((acc[MSB] == p_ext[MSB]) && (sum[MSB] != acc[MSB])) : carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg   <= '0;
      p_valid <= 1'b0;
    end else if (clr) begin
      p_valid <= 1'b0;
    end else if (accept) begin
      p_reg   <= prod;
      p_valid <= 1'b1;
    end else if (!stall) begin
      p_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
    end else if (clr) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
    end else if (advance) begin
      if (last) begin
        acc     <= '0;
        ovf_acc <= 1'b0;
        cnt     <= '0;
      end else begin
        acc     <= sum;
        ovf_acc <= ovf_acc | ovf;
        cnt     <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  // A completing product may reload the result on the same edge the old one is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (advance && !clr && last) begin
      out_valid <= 1'b1;
      out_acc   <= sum;
      out_ovf   <= ovf_acc | ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_accum_pipe.sv
// tb_mult_accum_pipe: four parameter variants share one stimulus stream; each
// scenario task checks the variant it targets against hand-computed results.
module tb_mult_accum_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       clr;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;

  logic        u_in_ready, u_out_valid, u_out_ovf;
  logic [23:0] u_out_acc;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [23:0] s_out_acc;
  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [15:0] w_out_acc;
  logic        o_in_ready, o_out_valid, o_out_ovf;
  logic [23:0] o_out_acc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_accum_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .a(a), .b(b),
    .clr(clr), .out_valid(u_out_valid), .out_ready(out_ready), .out_acc(u_out_acc),
    .out_ovf(u_out_ovf)
  );

  mult_accum_pipe #(.SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .clr(clr), .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
    .out_ovf(s_out_ovf)
  );

  mult_accum_pipe #(.ACC_WIDTH(16)) w_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .a(a), .b(b),
    .clr(clr), .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc),
    .out_ovf(w_out_ovf)
  );

  mult_accum_pipe #(.BLOCK_LEN(1)) o_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready), .a(a), .b(b),
    .clr(clr), .out_valid(o_out_valid), .out_ready(out_ready), .out_acc(o_out_acc),
    .out_ovf(o_out_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    clr       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    clr       = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 8'd9, 8'd9);
    step();
    checks++;
    if ({u_out_valid, u_out_ovf, u_in_ready, u_out_acc} !== {1'b0, 1'b0, 1'b1, 24'd0}) begin
      errors++;
      $display("[TB] FAIL reset_u: got v=%b ovf=%b rdy=%b acc=%h expected v=0 ovf=0 rdy=1 acc=0",
               u_out_valid, u_out_ovf, u_in_ready, u_out_acc);
    end
    checks++;
    if ({s_out_valid, s_out_ovf, s_in_ready, s_out_acc} !== {1'b0, 1'b0, 1'b1, 24'd0}) begin
      errors++;
      $display("[TB] FAIL reset_s: got v=%b ovf=%b rdy=%b acc=%h expected v=0 ovf=0 rdy=1 acc=0",
               s_out_valid, s_out_ovf, s_in_ready, s_out_acc);
    end
    checks++;
    if ({w_out_valid, w_out_ovf, w_in_ready, w_out_acc} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("[TB] FAIL reset_w: got v=%b ovf=%b rdy=%b acc=%h expected v=0 ovf=0 rdy=1 acc=0",
               w_out_valid, w_out_ovf, w_in_ready, w_out_acc);
    end
    checks++;
    if ({o_out_valid, o_out_ovf, o_in_ready, o_out_acc} !== {1'b0, 1'b0, 1'b1, 24'd0}) begin
      errors++;
      $display("[TB] FAIL reset_o: got v=%b ovf=%b rdy=%b acc=%h expected v=0 ovf=0 rdy=1 acc=0",
               o_out_valid, o_out_ovf, o_in_ready, o_out_acc);
    end
    rst = 1'b0;
    drive(1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_unsigned();
    do_reset();
    drive(1'b1, 8'd255, 8'd255);
    repeat (4) step();
    drive(1'b0, 8'd0, 8'd0);
    checks++;
    if (u_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unsigned_latency: out_valid got %b expected 0", u_out_valid);
    end
    step();
    checks++;
    if ({u_out_valid, u_out_ovf, u_out_acc} !== {1'b1, 1'b0, 24'h03F804}) begin
      errors++;
      $display("[TB] FAIL unsigned_result: got v=%b ovf=%b acc=%h expected v=1 ovf=0 acc=03f804",
               u_out_valid, u_out_ovf, u_out_acc);
    end
    step();
    checks++;
    if (u_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unsigned_consumed: out_valid got %b expected 0", u_out_valid);
    end
  endtask

  task automatic test_signed();
    do_reset();
    drive(1'b1, 8'h80, 8'h80);
    step();
    drive(1'b1, 8'hFF, 8'h01);
    step();
    drive(1'b1, 8'h7F, 8'h80);
    step();
    drive(1'b1, 8'h02, 8'h03);
    step();
    drive(1'b0, 8'd0, 8'd0);
    step();
    checks++;
    if ({s_out_valid, s_out_ovf, s_out_acc} !== {1'b1, 1'b0, 24'h000085}) begin
      errors++;
      $display("[TB] FAIL signed_result: got v=%b ovf=%b acc=%h expected v=1 ovf=0 acc=000085",
               s_out_valid, s_out_ovf, s_out_acc);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1'b1, 8'd255, 8'd255);
    repeat (4) step();
    drive(1'b1, 8'd1, 8'd1);
    step();
    checks++;
    if ({w_out_valid, w_out_ovf, w_out_acc} !== {1'b1, 1'b1, 16'hF804}) begin
      errors++;
      $display("[TB] FAIL overflow_wrap: got v=%b ovf=%b acc=%h expected v=1 ovf=1 acc=f804",
               w_out_valid, w_out_ovf, w_out_acc);
    end
    repeat (3) step();
    drive(1'b0, 8'd0, 8'd0);
    checks++;
    if (w_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_gap: out_valid got %b expected 0", w_out_valid);
    end
    step();
    checks++;
    if ({w_out_valid, w_out_ovf, w_out_acc} !== {1'b1, 1'b0, 16'd4}) begin
      errors++;
      $display("[TB] FAIL overflow_next_block: got v=%b ovf=%b acc=%h expected v=1 ovf=0 acc=0004",
               w_out_valid, w_out_ovf, w_out_acc);
    end
  endtask

  task automatic test_backpressure();
    bit found;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'd1, 8'd2);
    repeat (4) step();
    drive(1'b1, 8'd3, 8'd3);
    step();
    checks++;
    if ({u_out_valid, u_in_ready, u_out_acc} !== {1'b1, 1'b0, 24'd8}) begin
      errors++;
      $display("[TB] FAIL bp_first_result: got v=%b rdy=%b acc=%0d expected v=1 rdy=0 acc=8",
               u_out_valid, u_in_ready, u_out_acc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({u_out_valid, u_in_ready, u_out_acc} !== {1'b1, 1'b0, 24'd8}) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got v=%b rdy=%b acc=%0d expected v=1 rdy=0 acc=8",
                 i, u_out_valid, u_in_ready, u_out_acc);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (u_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_comb: in_ready got %b expected 1", u_in_ready);
    end
    repeat (3) step();
    drive(1'b0, 8'd0, 8'd0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (u_out_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL bp_second_timeout: out_valid got 0 expected 1 within 8 cycles");
    end else if (u_out_acc !== 24'd36) begin
      errors++;
      $display("[TB] FAIL bp_second_result: acc got %0d expected 36", u_out_acc);
    end
    step();
    checks++;
    if (u_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_no_extra: out_valid got %b expected 0", u_out_valid);
    end
  endtask

  task automatic test_clr();
    do_reset();
    drive(1'b1, 8'd7, 8'd7);
    repeat (2) step();
    clr = 1'b1;
    drive(1'b1, 8'd9, 8'd9);
    step();
    clr = 1'b0;
    drive(1'b1, 8'd1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (u_out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clr_premature_%0d: out_valid got %b expected 0", i, u_out_valid);
      end
      step();
    end
    drive(1'b0, 8'd0, 8'd0);
    step();
    checks++;
    if ({u_out_valid, u_out_acc} !== {1'b1, 24'd4}) begin
      errors++;
      $display("[TB] FAIL clr_flush_result: got v=%b acc=%0d expected v=1 acc=4", u_out_valid, u_out_acc);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (u_out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clr_single_%0d: out_valid got %b expected 0", i, u_out_valid);
      end
    end
    // Hold a result, park one sample in the product stage, then flush during the stall.
    out_ready = 1'b0;
    drive(1'b1, 8'd2, 8'd1);
    repeat (4) step();
    drive(1'b1, 8'd5, 8'd5);
    step();
    drive(1'b0, 8'd0, 8'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({u_out_valid, u_out_ovf, u_out_acc} !== {1'b1, 1'b0, 24'd8}) begin
      errors++;
      $display("[TB] FAIL clr_held_result: got v=%b ovf=%b acc=%0d expected v=1 ovf=0 acc=8",
               u_out_valid, u_out_ovf, u_out_acc);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (u_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_held_consumed: out_valid got %b expected 0", u_out_valid);
    end
    drive(1'b1, 8'd1, 8'd1);
    repeat (4) step();
    drive(1'b0, 8'd0, 8'd0);
    step();
    checks++;
    if ({u_out_valid, u_out_acc} !== {1'b1, 24'd4}) begin
      errors++;
      $display("[TB] FAIL clr_after_stall: got v=%b acc=%0d expected v=1 acc=4", u_out_valid, u_out_acc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 8'd3, 8'd4);
    step();
    drive(1'b1, 8'd5, 8'd6);
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_latency: out_valid got %b expected 0", o_out_valid);
    end
    step();
    drive(1'b1, 8'd7, 8'd7);
    checks++;
    if ({o_out_valid, o_out_acc} !== {1'b1, 24'd12}) begin
      errors++;
      $display("[TB] FAIL b2b_first: got v=%b acc=%0d expected v=1 acc=12", o_out_valid, o_out_acc);
    end
    step();
    drive(1'b0, 8'd0, 8'd0);
    checks++;
    if ({o_out_valid, o_out_acc} !== {1'b1, 24'd30}) begin
      errors++;
      $display("[TB] FAIL b2b_second: got v=%b acc=%0d expected v=1 acc=30", o_out_valid, o_out_acc);
    end
    step();
    checks++;
    if ({o_out_valid, o_out_ovf, o_out_acc} !== {1'b1, 1'b0, 24'd49}) begin
      errors++;
      $display("[TB] FAIL b2b_third: got v=%b ovf=%b acc=%0d expected v=1 ovf=0 acc=49",
               o_out_valid, o_out_ovf, o_out_acc);
    end
    step();
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: out_valid got %b expected 0", o_out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'd3, 8'd3);
    repeat (4) step();
    drive(1'b1, 8'd5, 8'd5);
    step();
    drive(1'b0, 8'd0, 8'd0);
    #2;
    checks++;
    if ({u_out_valid, u_out_acc} !== {1'b1, 24'd36}) begin
      errors++;
      $display("[TB] FAIL arst_pre_held: got v=%b acc=%0d expected v=1 acc=36", u_out_valid, u_out_acc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({u_out_valid, u_out_ovf, u_in_ready, u_out_acc} !== {1'b0, 1'b0, 1'b1, 24'd0}) begin
      errors++;
      $display("[TB] FAIL arst_immediate: got v=%b ovf=%b rdy=%b acc=%0d expected v=0 ovf=0 rdy=1 acc=0",
               u_out_valid, u_out_ovf, u_in_ready, u_out_acc);
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 8'd1, 8'd1);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b1, 8'd2, 8'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (u_out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL arst_midblock_%0d: out_valid got %b expected 0", i, u_out_valid);
      end
    end
    drive(1'b0, 8'd0, 8'd0);
    step();
    checks++;
    if ({u_out_valid, u_out_acc} !== {1'b1, 24'd16}) begin
      errors++;
      $display("[TB] FAIL arst_after: got v=%b acc=%0d expected v=1 acc=16", u_out_valid, u_out_acc);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_backpressure();
    test_clr();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
